// File: rtl/dcache_ctrl_pkg.sv
// cache_pkg: shared geometry constants and controller state encoding for the data cache
package cache_pkg;
   localparam int LINES    = 32;
   localparam int WORDS    = 4;
   localparam int TAG_W    = 23;
   localparam int INDEX_W  = 5;
   localparam int OFFSET_W = 2;
   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: word-wide main-memory request bus between the cache and memory
interface dcache_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_ctrl_array.sv
// dcache_array: valid/tag/data storage with async read by index and separate tag and word write ports
module dcache_array #(
   parameter int LINES = cache_pkg::LINES,
   parameter int WORDS = cache_pkg::WORDS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [cache_pkg::INDEX_W-1:0] rd_idx_i,
   output logic                          rd_valid_o,
   output logic [cache_pkg::TAG_W-1:0]   rd_tag_o,
   output logic [WORDS-1:0][31:0]        rd_line_o,
   input  logic                          tv_we_i,
   input  logic [cache_pkg::INDEX_W-1:0] tv_idx_i,
   input  logic [cache_pkg::TAG_W-1:0]   tv_tag_i,
   input  logic                          tv_valid_i,
   input  logic                          wd_we_i,
   input  logic [cache_pkg::INDEX_W-1:0] wd_idx_i,
   input  logic [cache_pkg::OFFSET_W-1:0] wd_off_i,
   input  logic [31:0]                   wd_data_i
);
   import cache_pkg::*;
   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES][WORDS];
   // valid bits are the only storage cleared by reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) valid_q <= '0;
      else if (tv_we_i) valid_q[tv_idx_i] <= tv_valid_i;
   // tag and data arrays keep their contents across reset
   always_ff @(posedge clk) begin
      if (tv_we_i) tag_q[tv_idx_i] <= tv_tag_i;
      if (wd_we_i) data_q[wd_idx_i][wd_off_i] <= wd_data_i;
   end
   // combinational lookup of the indexed line
   always_comb begin
      rd_valid_o = valid_q[rd_idx_i];
      rd_tag_o   = tag_q[rd_idx_i];
      for (int w = 0; w < WORDS; w++) rd_line_o[w] = data_q[rd_idx_i][w];
   end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through, no-write-allocate data cache controller
module dcache_ctrl #(
   parameter int LINES = cache_pkg::LINES,
   parameter int WORDS = cache_pkg::WORDS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic [31:0]   Addr,
   input  logic [31:0]   WriteData,
   output logic [31:0]   ReadData,
   output logic          Stall,
   dcache_ctrl_if.master mem,
   output logic [31:0]   hit_cnt,
   output logic [31:0]   miss_cnt
);
   import cache_pkg::*;
   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [31:2]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                fill_q, fill_d;
   logic [31:0]         hit_q, miss_q;
   logic                hit_inc, miss_inc, stall_c;
   logic [TAG_W-1:0]    tag_in, rd_tag, tv_tag;
   logic [INDEX_W-1:0]  idx_in, tv_idx, wd_idx;
   logic [OFFSET_W-1:0] off_in, wd_off;
   logic                rd_valid, hit, tv_we, tv_valid, wd_we;
   logic [WORDS-1:0][31:0] rd_line;
   logic [31:0]         wd_data;
   logic                unused_addr;
   assign tag_in      = Addr[31:9];
   assign idx_in      = Addr[8:4];
   assign off_in      = Addr[3:2];
   assign unused_addr = ^Addr[1:0];
   assign hit         = rd_valid & (rd_tag == tag_in);
   assign tv_idx      = (state_q == IDLE) ? idx_in : addr_q[8:4];
   assign tv_tag      = (state_q == IDLE) ? tag_in : addr_q[31:9];
   assign Stall       = stall_c & rst_n;
   assign hit_cnt     = hit_q;
   assign miss_cnt    = miss_q;
   dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (idx_in),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_line_o  (rd_line),
      .tv_we_i    (tv_we),
      .tv_idx_i   (tv_idx),
      .tv_tag_i   (tv_tag),
      .tv_valid_i (tv_valid),
      .wd_we_i    (wd_we),
      .wd_idx_i   (wd_idx),
      .wd_off_i   (wd_off),
      .wd_data_i  (wd_data)
   );
   // state, latched request and saturating performance counters
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fill_q  <= 1'b0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fill_q  <= fill_d;
         hit_q   <= hit_q + 32'(hit_inc && hit_q != '1);
         miss_q  <= miss_q + 32'(miss_inc && miss_q != '1);
      end
   // next state, cache array writes and bus/CPU outputs; fill_q hides the hit that follows a refill
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      fill_d        = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
      stall_c       = 1'b0;
      ReadData      = '0;
      tv_we         = 1'b0;
      tv_valid      = 1'b0;
      wd_we         = 1'b0;
      wd_idx        = idx_in;
      wd_off        = off_in;
      wd_data       = WriteData;
      mem.mem_req   = state_q != IDLE;
      mem.mem_we    = state_q == WRITE;
      mem.mem_addr  = (state_q == REFILL) ? {addr_q[31:4], cnt_q, 2'b00} : {addr_q, 2'b00};
      mem.mem_wdata = wdata_q;
      unique case (state_q)
         IDLE:
            if (MemWrite) begin
               addr_d  = Addr[31:2];
               wdata_d = WriteData;
               stall_c = 1'b1;
               wd_we   = hit;
               state_d = WRITE;
            end else if (MemRead && hit) begin
               ReadData = rd_line[off_in];
               hit_inc  = ~fill_q;
            end else if (MemRead) begin
               addr_d   = Addr[31:2];
               cnt_d    = '0;
               stall_c  = 1'b1;
               miss_inc = 1'b1;
               tv_we    = 1'b1;
               state_d  = REFILL;
            end
         REFILL: begin
            stall_c = 1'b1;
            wd_idx  = addr_q[8:4];
            wd_off  = cnt_q;
            wd_data = mem.mem_rdata;
            if (mem.mem_ready) begin
               wd_we = 1'b1;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  tv_we    = 1'b1;
                  tv_valid = 1'b1;
                  fill_d   = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         WRITE: begin
            stall_c = ~mem.mem_ready;
            if (mem.mem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scoreboard bench for dcache_ctrl with a latency-programmable memory model
module tb_dcache_ctrl;
   typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
   logic        clk = 1'b0, rst_n = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
   logic [31:0] Addr = '0, WriteData = '0, ReadData, hit_cnt, miss_cnt;
   logic        Stall;
   logic [31:0] mem [0:32767];
   int          lat = 0, w = 0, passed = 0, total = 0;
   logic        spur = 1'b0;
   txn_t        log_q [$];
   logic [31:0] exp_q [$];
   logic        mvalid [32];
   logic [22:0] mtag [32];
   int          hit_m = 0, miss_m = 0;

   dcache_ctrl_if mif ();
   dcache_ctrl dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr),
      .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .mem(mif),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;
   assign mif.mem_ready = (mif.mem_req && w >= lat) || spur;
   assign mif.mem_rdata = mem[mif.mem_addr[16:2]];
   always @(posedge clk) begin
      w <= (mif.mem_req && !mif.mem_ready) ? w + 1 : 0;
      if (mif.mem_req && mif.mem_ready) begin
         log_q.push_back('{mif.mem_we, mif.mem_addr, mif.mem_wdata});
         if (mif.mem_we) mem[mif.mem_addr[16:2]] = mif.mem_wdata;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic mhit(logic [31:0] a);
      return mvalid[a[8:4]] && mtag[a[8:4]] == a[31:9];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
      hit_m = 0;
      miss_m = 0;
   endtask

   task automatic wait_release(string tag, int exp_n);
      int n = 0;
      forever begin
         @(negedge clk);
         if (!Stall) break;
         n++;
         if (n > 200) break;
      end
      chk(tag, 32'(n), 32'(exp_n));
   endtask

   task automatic do_lw(logic [31:0] a);
      logic h = mhit(a);
      @(posedge clk); #1;
      MemRead = 1'b1; MemWrite = 1'b0; Addr = a;
      exp_q.push_back(mem[a[16:2]]);
      log_q.delete();
      wait_release("lw_stall", h ? 0 : 1 + 4 * (lat + 1));
      chk("lw_data", ReadData, exp_q.pop_front());
      if (h) chk("lw_hit_noreq", 32'(log_q.size()), 0);
      else begin
         chk("lw_refill_reqs", 32'(log_q.size()), 4);
         for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("lw_refill_addr", log_q[i].addr, {a[31:4], 4'(i * 4)});
            chk("lw_refill_we", 32'(log_q[i].we), 0);
         end
      end
      if (h) hit_m++;
      else begin
         miss_m++;
         mvalid[a[8:4]] = 1'b1;
         mtag[a[8:4]] = a[31:9];
      end
      @(posedge clk); #1;
      MemRead = 1'b0;
      chk("hit_cnt", hit_cnt, 32'(hit_m));
      chk("miss_cnt", miss_cnt, 32'(miss_m));
   endtask

   task automatic do_sw(logic [31:0] a, logic [31:0] d, logic rd);
      @(posedge clk); #1;
      MemRead = rd; MemWrite = 1'b1; Addr = a; WriteData = d;
      log_q.delete();
      wait_release("sw_stall", 1 + lat);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      chk("sw_reqs", 32'(log_q.size()), 1);
      if (log_q.size() == 1) begin
         chk("sw_we", 32'(log_q[0].we), 1);
         chk("sw_addr", log_q[0].addr, a);
         chk("sw_data", log_q[0].data, d);
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = {16'(i), 16'h5A00 ^ 16'(i * 7)};
      mem[32'h100 >> 2] = 32'hDEADBEEF;
      clear_model();
      repeat (2) @(negedge clk);
      chk("rst_stall", 32'(Stall), 0);
      chk("rst_req", 32'(mif.mem_req), 0);
      chk("rst_we", 32'(mif.mem_we), 0);
      chk("rst_hits", hit_cnt, 0);
      chk("rst_miss", miss_cnt, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_rdata", ReadData, 0);
      chk("idle_stall", 32'(Stall), 0);
      chk("idle_req", 32'(mif.mem_req), 0);
      do_lw(32'h100);
      do_lw(32'h104);
      lat = 2;
      do_sw(32'h108, 32'h12345678, 1'b0);
      lat = 0;
      do_lw(32'h108);
      chk("sw_hit_value", mem[32'h108 >> 2], 32'h12345678);
      do_sw(32'h2000, 32'h0BADF00D, 1'b0);
      do_lw(32'h2000);
      do_lw(32'h300);
      do_lw(32'h10300);
      do_lw(32'h300);
      do_sw(32'h304, 32'hCAFEF00D, 1'b1);
      do_lw(32'h304);
      @(posedge clk); #1 spur = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("spur_stall", 32'(Stall), 0);
         chk("spur_req", 32'(mif.mem_req), 0);
      end
      @(posedge clk); #1 spur = 1'b0;
      do_lw(32'h104);
      lat = 1;
      do_lw(32'h5000);
      lat = 0;
      @(posedge clk); #1;
      MemRead = 1'b1; Addr = 32'h6000;
      log_q.delete();
      repeat (4) @(negedge clk);
      chk("mid_refill_req", 32'(mif.mem_req), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rr_req", 32'(mif.mem_req), 0);
      chk("rr_stall", 32'(Stall), 0);
      chk("rr_hits", hit_cnt, 0);
      chk("rr_miss", miss_cnt, 0);
      MemRead = 1'b0;
      clear_model();
      @(posedge clk); #1 rst_n = 1'b1;
      do_lw(32'h6000);
      do_lw(32'h100);
      lat = 5;
      @(posedge clk); #1;
      MemWrite = 1'b1; Addr = 32'h7000; WriteData = 32'h77777777;
      repeat (3) @(negedge clk);
      chk("mid_write_we", 32'(mif.mem_we), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_req", 32'(mif.mem_req), 0);
      chk("rw_we", 32'(mif.mem_we), 0);
      chk("rw_stall", 32'(Stall), 0);
      MemWrite = 1'b0;
      clear_model();
      log_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rw_no_retry", 32'(log_q.size()), 0);
      chk("rw_mem_untouched", 32'(mem[32'h7000 >> 2] == 32'h77777777), 0);
      lat = 0;
      do_lw(32'h100);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
